// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - mode and breathe-state encodings for the status-LED PWM driver
package led_pwm_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   typedef enum logic {
      BR_RISE = 1'b0,
      BR_FALL = 1'b1
   } br_state_e;

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED channel: shadow/active config, breathe FSM, duty compare, pad register (optional LED_PWM_GAMMA_EN)
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk_48mhz,
   input  logic                reset_n,
   input  logic                period_start,
   input  logic                cfg_wr,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   input  logic                blink_dark,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led
);

   localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
   localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);

   mode_e               shadow_mode, act_mode, mode_new, act_mode_nxt;
   logic [PWM_BITS-1:0] shadow_duty, act_duty, duty_new, act_duty_nxt;
   logic [PWM_BITS-1:0] level, level_nxt, duty_eff, duty_cmp;
   br_state_e           br_state, br_state_nxt;
   logic                lit;

   // A write landing in the boundary cycle is forwarded straight into the new period.
   assign mode_new     = cfg_wr ? mode_e'(cfg_mode) : shadow_mode;
   assign duty_new     = cfg_wr ? cfg_duty : shadow_duty;
   assign act_mode_nxt = period_start ? mode_new : act_mode;
   assign act_duty_nxt = period_start ? duty_new : act_duty;

   // Config registers: shadow takes every write, active reloads only at a period boundary
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         shadow_mode <= MODE_OFF;
         shadow_duty <= '0;
         act_mode    <= MODE_OFF;
         act_duty    <= '0;
      end else begin
         if (cfg_wr) begin
            shadow_mode <= mode_e'(cfg_mode);
            shadow_duty <= cfg_duty;
         end
         act_mode <= act_mode_nxt;
         act_duty <= act_duty_nxt;
      end
   end

   // Breathe FSM state and level register
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         br_state <= BR_RISE;
         level    <= '0;
      end else begin
         br_state <= br_state_nxt;
         level    <= level_nxt;
      end
   end

   // Breathe next-state: one step per period, restart on entry, clamp when duty drops below level
   always_comb begin
      br_state_nxt = br_state;
      level_nxt    = level;
      if (period_start) begin
         if (mode_new != MODE_BREATHE || act_mode != MODE_BREATHE) begin
            level_nxt    = '0;
            br_state_nxt = BR_RISE;
         end else if (duty_new < level) begin
            level_nxt    = duty_new;
            br_state_nxt = BR_FALL;
         end else begin
            case (br_state)
               BR_RISE: begin
                  if (level < duty_new) begin
                     level_nxt = level + ONE;
                     if (level + ONE == duty_new) br_state_nxt = BR_FALL;
                  end else begin
                     br_state_nxt = BR_FALL;
                  end
               end
               default: begin
                  if (level != '0) begin
                     level_nxt = level - ONE;
                     if (level == ONE) br_state_nxt = BR_RISE;
                  end else begin
                     br_state_nxt = BR_RISE;
                  end
               end
            endcase
         end
      end
   end

   // Effective duty from post-boundary values so the first tick of a period already sees new config
   always_comb begin
      duty_eff = '0;
      case (act_mode_nxt)
         MODE_ON:      duty_eff = act_duty_nxt;
         MODE_BLINK:   duty_eff = blink_dark ? '0 : act_duty_nxt;
         MODE_BREATHE: duty_eff = level_nxt;
         default:      duty_eff = '0;
      endcase
   end

`ifdef LED_PWM_GAMMA_EN
   function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] d);
      logic [2*PWM_BITS-1:0] sq;
      sq = (2*PWM_BITS)'(d) * (2*PWM_BITS)'(d);
      return (d == DUTY_FULL) ? DUTY_FULL : sq[2*PWM_BITS-1:PWM_BITS];
   endfunction

   // Gamma stage register; the top delays pwm_cnt by one cycle to stay paired with it
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) duty_cmp <= '0;
      else          duty_cmp <= gamma(duty_eff);
   end
`else
   assign duty_cmp = duty_eff;
`endif

   assign lit = (duty_cmp == DUTY_FULL) || (pwm_cnt < duty_cmp);

   // Pad register, dark at reset
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) led <= ACTIVE_LOW;
      else          led <= lit ^ ACTIVE_LOW;
   end

endmodule

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel status-LED PWM driver top: timebase, blink phase, config decode (optional LED_PWM_GAMMA_EN)
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int NUM_CH        = 3,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE      = 188,
   parameter int BLINK_PERIODS = 128,
   parameter bit ACTIVE_LOW    = 1'b1,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk_48mhz,
   input  logic                reset_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic [NUM_CH-1:0]   led,
   output logic                period_start
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

   logic [PS_W-1:0]     presc;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt, cmp_cnt;
   logic                ps_q;
   logic [BL_W-1:0]     blink_cnt;
   logic                blink_wrap, blink_phase, blink_phase_nxt;

   assign tick            = (presc == PS_W'(PRESCALE - 1));
   assign blink_wrap      = ps_q && (blink_cnt == BL_W'(BLINK_PERIODS - 1));
   assign blink_phase_nxt = blink_wrap ? ~blink_phase : blink_phase;

   // Timebase: prescaler, free-running PWM counter and the period-boundary strobe
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         presc   <= '0;
         pwm_cnt <= '0;
         ps_q    <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PS_W'(1);
         if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         ps_q  <= tick && (pwm_cnt == '1);
      end
   end

   // Blink timebase shared by all channels: count periods, flip phase on wrap
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (ps_q) blink_cnt <= blink_wrap ? '0 : blink_cnt + BL_W'(1);
         blink_phase <= blink_phase_nxt;
      end
   end

`ifdef LED_PWM_GAMMA_EN
   logic [PWM_BITS-1:0] cnt_dly;
   logic                ps_dly;

   // Delay compare count and boundary pulse to line up with the channel gamma register
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         cnt_dly <= '0;
         ps_dly  <= 1'b0;
      end else begin
         cnt_dly <= pwm_cnt;
         ps_dly  <= ps_q;
      end
   end

   assign cmp_cnt      = cnt_dly;
   assign period_start = ps_dly;
`else
   assign cmp_cnt      = pwm_cnt;
   assign period_start = ps_q;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk_48mhz    (clk_48mhz),
         .reset_n      (reset_n),
         .period_start (ps_q),
         .cfg_wr       (cfg_we && (cfg_ch == CH_W'(i))),
         .cfg_mode     (cfg_mode),
         .cfg_duty     (cfg_duty),
         .blink_dark   (blink_phase_nxt),
         .pwm_cnt      (cmp_cnt),
         .led          (led[i])
      );
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - self-checking bench for led_pwm_ctrl with per-period lit-cycle scoreboard
module tb_led_pwm_ctrl;

   localparam int NUM_CH        = 3;
   localparam int PWM_BITS      = 4;
   localparam int PRESCALE      = 2;
   localparam int BLINK_PERIODS = 2;
   localparam int PERIOD        = PRESCALE << PWM_BITS;

   localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_BREATHE = 3;

   logic              clk_48mhz = 1'b0;
   logic              reset_n   = 1'b0;
   logic              cfg_we    = 1'b0;
   logic [1:0]        cfg_ch    = '0;
   logic [1:0]        cfg_mode  = '0;
   logic [3:0]        cfg_duty  = '0;
   logic [NUM_CH-1:0] led;
   logic              period_start;

   int checks   = 0;
   int failures = 0;
   int period_n = 0;

   typedef struct {
      int         at;
      logic [1:0] ch;
      logic [1:0] mode;
      logic [3:0] duty;
   } wr_t;

   logic [23:0] exp_q[$];

   led_pwm_ctrl #(
      .NUM_CH        (NUM_CH),
      .PWM_BITS      (PWM_BITS),
      .PRESCALE      (PRESCALE),
      .BLINK_PERIODS (BLINK_PERIODS),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk_48mhz    (clk_48mhz),
      .reset_n      (reset_n),
      .cfg_we       (cfg_we),
      .cfg_ch       (cfg_ch),
      .cfg_mode     (cfg_mode),
      .cfg_duty     (cfg_duty),
      .led          (led),
      .period_start (period_start)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   function automatic wr_t mk(input int at, input int ch, input int mode, input int duty);
      wr_t w;
      w.at = at; w.ch = 2'(ch); w.mode = 2'(mode); w.duty = 4'(duty);
      return w;
   endfunction

   function automatic int lit_cycles(input int d);
      return (d == 15) ? PERIOD : d * PRESCALE;
   endfunction

   function automatic int blink_cycles(input int n, input int d);
      return (((n / BLINK_PERIODS) % 2) == 0) ? lit_cycles(d) : 0;
   endfunction

   function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
      return {8'(c2), 8'(c1), 8'(c0)};
   endfunction

   task automatic drive(input wr_t w);
      cfg_we   = 1'b1;
      cfg_ch   = w.ch;
      cfg_mode = w.mode;
      cfg_duty = w.duty;
   endtask

   task automatic sync_ps(output int n);
      n = -1;
      for (int i = 1; i <= 2 * PERIOD; i++) begin
         @(negedge clk_48mhz);
         if (period_start === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Entered at the negedge of a period_start cycle; counts lit cycles over one full period.
   task automatic run_period(input wr_t w1, input wr_t w2, output logic [23:0] got, output logic ps_ok);
      int cnt[3];
      cnt = '{0, 0, 0};
      if (w1.at == 0) drive(w1);
      for (int i = 1; i <= PERIOD; i++) begin
         @(negedge clk_48mhz);
         cfg_we = 1'b0;
         if (w1.at == i) drive(w1);
         if (w2.at == i) drive(w2);
         for (int c = 0; c < NUM_CH; c++) if (led[c] === 1'b0) cnt[c]++;
      end
      got   = pk(cnt[0], cnt[1], cnt[2]);
      ps_ok = (period_start === 1'b1);
      period_n++;
   endtask

   task automatic test_reset();
      int n;
      logic [23:0] got, e;
      logic ps_ok;
      reset_n = 1'b0;
      repeat (3) @(negedge clk_48mhz);
      checks++;
      if (led !== 3'b111) begin failures++; $display("FAIL reset_led: led=%b required 111", led); end
      checks++;
      if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps: period_start=%b required 0", period_start); end
      reset_n = 1'b1;
      sync_ps(n);
      checks++;
      if (n !== PERIOD) begin failures++; $display("FAIL first_ps: cycles=%0d required %0d", n, PERIOD); end
      period_n = 1;
      exp_q.push_back(pk(0, 0, 0));
      run_period(mk(-1, 0, 0, 0), mk(-1, 0, 0, 0), got, ps_ok);
      checks++;
      if (!ps_ok) begin failures++; $display("FAIL idle_period_len: period_start=0 required 1"); end
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL idle_lit: {ch2,ch1,ch0}=%h required %h", got, e); end
   endtask

   task automatic test_on();
      wr_t w[4];
      int  d[4];
      logic [23:0] got, e;
      logic ps_ok;
      w[0] = mk(0, 0, M_ON, 4);  d[0] = 4;
      w[1] = mk(-1, 0, 0, 0);    d[1] = 4;
      w[2] = mk(0, 0, M_ON, 15); d[2] = 15;
      w[3] = mk(0, 0, M_ON, 0);  d[3] = 0;
      for (int p = 0; p < 4; p++) begin
         exp_q.push_back(pk(lit_cycles(d[p]), 0, 0));
         run_period(w[p], mk(-1, 0, 0, 0), got, ps_ok);
         checks++;
         if (!ps_ok) begin failures++; $display("FAIL on_period_len[%0d]: period_start=0 required 1", p); end
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin failures++; $display("FAIL on_lit[%0d]: {ch2,ch1,ch0}=%h required %h", p, got, e); end
      end
   endtask

   task automatic test_double_buffer();
      wr_t w1[4], w2[4];
      int  d1[4];
      logic [23:0] got, e;
      logic ps_ok;
      w1[0] = mk(10, 1, M_ON, 8);  w2[0] = mk(-1, 0, 0, 0);       d1[0] = 0;
      w1[1] = mk(7, 3, M_ON, 15);  w2[1] = mk(-1, 0, 0, 0);       d1[1] = 8;
      w1[2] = mk(4, 1, M_ON, 2);   w2[2] = mk(20, 1, M_ON, 5);    d1[2] = 8;
      w1[3] = mk(-1, 0, 0, 0);     w2[3] = mk(-1, 0, 0, 0);       d1[3] = 5;
      for (int p = 0; p < 4; p++) begin
         exp_q.push_back(pk(0, lit_cycles(d1[p]), 0));
         run_period(w1[p], w2[p], got, ps_ok);
         checks++;
         if (!ps_ok) begin failures++; $display("FAIL dbuf_period_len[%0d]: period_start=0 required 1", p); end
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin failures++; $display("FAIL dbuf_lit[%0d]: {ch2,ch1,ch0}=%h required %h", p, got, e); end
      end
   endtask

   task automatic test_blink();
      wr_t w[5];
      logic [23:0] got, e;
      logic ps_ok;
      w[0] = mk(5, 1, M_OFF, 0);
      w[1] = mk(0, 2, M_BLINK, 15);
      for (int p = 2; p < 5; p++) w[p] = mk(-1, 0, 0, 0);
      for (int p = 0; p < 5; p++) begin
         exp_q.push_back(pk(0, (p == 0) ? lit_cycles(5) : 0, (p == 0) ? 0 : blink_cycles(period_n, 15)));
         run_period(w[p], mk(-1, 0, 0, 0), got, ps_ok);
         checks++;
         if (!ps_ok) begin failures++; $display("FAIL blink_period_len[%0d]: period_start=0 required 1", p); end
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin failures++; $display("FAIL blink_lit[%0d]: {ch2,ch1,ch0}=%h required %h", p, got, e); end
      end
   endtask

   task automatic test_breathe();
      int  lvl[14];
      wr_t w[14];
      logic [23:0] got, e;
      logic ps_ok;
      lvl = '{0, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 1, 0, 1};
      for (int p = 0; p < 14; p++) w[p] = mk(-1, 0, 0, 0);
      w[0]  = mk(5, 2, M_OFF, 0);
      w[1]  = mk(0, 0, M_BREATHE, 3);
      w[10] = mk(10, 0, M_BREATHE, 1);
      for (int p = 0; p < 14; p++) begin
         exp_q.push_back(pk(lvl[p] * PRESCALE, 0, (p == 0) ? blink_cycles(period_n, 15) : 0));
         run_period(w[p], mk(-1, 0, 0, 0), got, ps_ok);
         checks++;
         if (!ps_ok) begin failures++; $display("FAIL breathe_period_len[%0d]: period_start=0 required 1", p); end
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin failures++; $display("FAIL breathe_lit[%0d]: {ch2,ch1,ch0}=%h required %h", p, got, e); end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [23:0] got, e;
      logic ps_ok;
      exp_q.push_back(pk(0, 0, 0));
      run_period(mk(3, 0, M_ON, 15), mk(6, 1, M_ON, 15), got, ps_ok);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL rmid_pre_lit: {ch2,ch1,ch0}=%h required %h", got, e); end
      exp_q.push_back(pk(PERIOD, PERIOD, PERIOD));
      run_period(mk(0, 2, M_ON, 15), mk(-1, 0, 0, 0), got, ps_ok);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL rmid_all_lit: {ch2,ch1,ch0}=%h required %h", got, e); end
      repeat (10) @(negedge clk_48mhz);
      checks++;
      if (led !== 3'b000) begin failures++; $display("FAIL rmid_lit_before: led=%b required 000", led); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (led !== 3'b111) begin failures++; $display("FAIL rmid_async_led: led=%b required 111", led); end
      checks++;
      if (period_start !== 1'b0) begin failures++; $display("FAIL rmid_ps: period_start=%b required 0", period_start); end
      repeat (2) @(negedge clk_48mhz);
      reset_n = 1'b1;
      sync_ps(n);
      checks++;
      if (n !== PERIOD) begin failures++; $display("FAIL rmid_first_ps: cycles=%0d required %0d", n, PERIOD); end
      period_n = 1;
      exp_q.push_back(pk(0, 0, 0));
      run_period(mk(-1, 0, 0, 0), mk(-1, 0, 0, 0), got, ps_ok);
      checks++;
      if (!ps_ok) begin failures++; $display("FAIL rmid_period_len: period_start=0 required 1"); end
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL rmid_off_after: {ch2,ch1,ch0}=%h required %h", got, e); end
   endtask

   initial begin
      test_reset();
      test_on();
      test_double_buffer();
      test_blink();
      test_breathe();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
